// File: rtl/conv_pad_streamer.sv
`default_nettype none
// ============================================================================
// Module      : conv_pad_streamer
// Description : Source side of the pixel stream that feeds the 3x3 line-buffer
//               convolution kernel. Takes an unpadded raster image
//               (IMAGE_WIDTH pixels per row, any height, end of frame marked by
//               i_last on the final pixel) and emits the zero-padded frame the
//               kernel expects: PAD zero rows top and bottom, and PAD zeros on
//               the left and right of every image row. Honours the kernel's
//               ready as backpressure.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   IMAGE_WIDTH  unpadded pixels per row
//   PIXEL_DATAW  pixel width (unsigned)
//   PAD          border width, (FILTER_SIZE-1)/2, legal 1..4
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   i_valid  in   upstream pixel valid
//   i_x      in   upstream pixel
//   i_last   in   upstream pixel is the last of the frame
//   o_ready  out  this block accepts i_x this cycle
//   i_ready  in   downstream (conv kernel) ready
//   o_valid  out  padded-stream beat valid
//   o_y      out  padded-stream pixel
//   o_last   out  final beat of the padded frame
//   o_err    out  sticky framing error
// Build option
//   PAD_FRAME_CHECK_EN : when defined, o_err flags misplaced i_last markers;
//                        when undefined, o_err is tied low and no check
//                        logic exists.
// ============================================================================
module conv_pad_streamer #(
  parameter int IMAGE_WIDTH = 512,
  parameter int PIXEL_DATAW = 8,
  parameter int PAD         = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [PIXEL_DATAW-1:0] i_x,
  input  logic                   i_last,
  output logic                   o_ready,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [PIXEL_DATAW-1:0] o_y,
  output logic                   o_last,
  output logic                   o_err
);

  // Padded row length and counter widths.
  localparam int c_w2    = IMAGE_WIDTH + 2 * PAD;
  localparam int c_col_w = $clog2(c_w2);
  localparam int c_row_w = 3;

  // Column landmarks inside one padded row. The column counter runs over the
  // whole padded row: left pad, then body, then right pad.
  localparam logic [c_col_w-1:0] c_col_last     = c_col_w'(c_w2 - 1);
  localparam logic [c_col_w-1:0] c_col_lpad_end = c_col_w'(PAD - 1);
  localparam logic [c_col_w-1:0] c_col_body_end = c_col_w'(PAD + IMAGE_WIDTH - 1);
  localparam logic [c_col_w-1:0] c_col_one      = c_col_w'(1);
  localparam logic [c_row_w-1:0] c_row_last     = c_row_w'(PAD - 1);
  localparam logic [c_row_w-1:0] c_row_one      = c_row_w'(1);

  // Frame sequencer states.
  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_top    = 3'd1;
  localparam logic [2:0] c_st_lpad   = 3'd2;
  localparam logic [2:0] c_st_body   = 3'd3;
  localparam logic [2:0] c_st_rpad   = 3'd4;
  localparam logic [2:0] c_st_bottom = 3'd5;

  logic [2:0]             r_state;
  logic [c_col_w-1:0]     r_col;
  logic [c_row_w-1:0]     r_row;
  logic                   r_eof;
  logic                   r_valid;
  logic [PIXEL_DATAW-1:0] r_y;
  logic                   r_last;

  logic [2:0]             w_state_nxt;
  logic [c_col_w-1:0]     w_col_nxt;
  logic [c_row_w-1:0]     w_row_nxt;
  logic                   w_eof_nxt;
  logic                   w_load;
  logic [PIXEL_DATAW-1:0] w_beat_y;
  logic                   w_beat_last;
  logic                   w_slot_free;
  logic                   w_accept;

  // The single output register may take a new beat when it is empty or its
  // current beat is being consumed this cycle.
  assign w_slot_free = ~r_valid | i_ready;
  assign o_ready     = (r_state == c_st_body) & w_slot_free;
  assign w_accept    = i_valid & o_ready;

  assign o_valid = r_valid;
  assign o_y     = r_y;
  assign o_last  = r_last;

  // --------------------------------------------------------------------------
  // Next-state / beat generation
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_eof_nxt   = r_eof;
    w_load      = 1'b0;
    w_beat_y    = '0;
    w_beat_last = 1'b0;

    case (r_state)
      c_st_idle: begin
        // The waiting pixel is only a trigger here; it is consumed in BODY
        // after the top border has been emitted.
        if (i_valid) begin
          w_state_nxt = c_st_top;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end
      end

      c_st_top: begin
        if (w_slot_free) begin
          w_load = 1'b1;
          if (r_col == c_col_last) begin
            w_col_nxt = '0;
            if (r_row == c_row_last) begin
              w_row_nxt   = '0;
              w_state_nxt = c_st_lpad;
            end else begin
              w_row_nxt = r_row + c_row_one;
            end
          end else begin
            w_col_nxt = r_col + c_col_one;
          end
        end
      end

      c_st_lpad: begin
        if (w_slot_free) begin
          w_load    = 1'b1;
          w_col_nxt = r_col + c_col_one;
          if (r_col == c_col_lpad_end) begin
            w_state_nxt = c_st_body;
          end
        end
      end

      c_st_body: begin
        // Upstream bubbles simply leave the output slot empty.
        if (w_accept) begin
          w_load    = 1'b1;
          w_beat_y  = i_x;
          w_col_nxt = r_col + c_col_one;
          if (r_col == c_col_body_end) begin
            // Only the marker on the final pixel of a row ends the frame.
            w_eof_nxt   = i_last;
            w_state_nxt = c_st_rpad;
          end
        end
      end

      c_st_rpad: begin
        if (w_slot_free) begin
          w_load = 1'b1;
          if (r_col == c_col_last) begin
            w_col_nxt   = '0;
            w_row_nxt   = '0;
            w_state_nxt = r_eof ? c_st_bottom : c_st_lpad;
          end else begin
            w_col_nxt = r_col + c_col_one;
          end
        end
      end

      c_st_bottom: begin
        if (w_slot_free) begin
          w_load = 1'b1;
          if (r_col == c_col_last) begin
            w_col_nxt = '0;
            if (r_row == c_row_last) begin
              w_row_nxt   = '0;
              w_beat_last = 1'b1;
              w_eof_nxt   = 1'b0;
              w_state_nxt = c_st_idle;
            end else begin
              w_row_nxt = r_row + c_row_one;
            end
          end else begin
            w_col_nxt = r_col + c_col_one;
          end
        end
      end

      default: begin
        w_state_nxt = c_st_idle;
        w_col_nxt   = '0;
        w_row_nxt   = '0;
        w_eof_nxt   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_col   <= '0;
      r_row   <= '0;
      r_eof   <= 1'b0;
      r_valid <= 1'b0;
      r_y     <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_eof   <= w_eof_nxt;
      if (w_load) begin
        r_valid <= 1'b1;
        r_y     <= w_beat_y;
        r_last  <= w_beat_last;
      end else if (i_ready) begin
        // Beat consumed with nothing to replace it: slot empties.
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional framing check
  // --------------------------------------------------------------------------
`ifdef PAD_FRAME_CHECK_EN
  logic r_err;
  logic r_last_taken;
  logic w_last_taken;
  logic w_bad_last;
  logic w_short_frame;

  assign w_last_taken = r_valid & r_last & i_ready;

  // End-of-frame marker on a body pixel that is not the end of a row.
  assign w_bad_last = w_accept & i_last & (r_col != c_col_body_end);

  // A new frame whose very first pixel already carries the end marker,
  // arriving right as the previous frame's final beat leaves.
  assign w_short_frame = (r_state == c_st_idle) & i_valid & i_last &
                         (w_last_taken | r_last_taken);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err        <= 1'b0;
      r_last_taken <= 1'b0;
    end else begin
      r_last_taken <= w_last_taken;
      if (w_bad_last | w_short_frame) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule
`default_nettype wire
